// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start/data/parity/stop sequencing).
// Latency: strobes are combinational from the state/edge_cnt registers; data_valid is registered,
//          so it is high the cycle after CHECK.
// Backpressure: none; the serial line cannot be stalled, and frames run at the PRESCALE rate.
//
// Ports:
//   CLK, RST            oversampling clock (rising edge), asynchronous active-low reset
//   RX_IN               serial line, idle high; a low level in IDLE starts a frame
//   PAR_EN              parity bit present; captured once per frame at IDLE->START
//   PRESCALE[5:0]       oversampling ratio (8, 16 or 32)
//   sampled_bit         majority-voted bit from the data sampler
//   strt_glitch, par_err, stp_err   registered checker results
//   dat_samp_en         sampler enable, high in START/DATA/PARITY/STOP
//   strt_chk_en, par_chk_en, stp_chk_en, deser_en   one-cycle strobes at the mid-bit tick
//   edge_cnt[5:0]       oversample tick within the current bit
//   bit_cnt[3:0]        data-bit index within DATA
//   data_valid          one-cycle pulse for an error-free frame
//   brk_det             (only with UART_RX_BREAK_DET_EN) break: all-zero data and stop error
//
// Optional feature macro: UART_RX_BREAK_DET_EN adds the brk_det output and its data flag.

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] PRESCALE,
    input  logic       sampled_bit,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_valid
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic       brk_det
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t     state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       par_en_q, par_en_d;
    logic       data_valid_q, data_valid_d;

    logic [5:0] mid_tick;
    logic       bit_end;
    logic       at_mid;
    logic       start_det;

    // Checkers sample two ticks past the nominal bit centre so the
    // sampler's three-vote window has settled.
    assign mid_tick  = (PRESCALE >> 1) + 6'd2;
    assign bit_end   = (edge_cnt_q == (PRESCALE - 6'd1));
    assign at_mid    = (edge_cnt_q == mid_tick);
    assign start_det = (state_q == IDLE) && !RX_IN;

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        data_valid_d = 1'b0;
        dat_samp_en  = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        deser_en     = 1'b0;

        // Free-running bit timer in every bit-carrying state.
        if (state_q != IDLE && state_q != CHECK) begin
            edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 4'd0;
                if (!RX_IN) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = at_mid;
                if (bit_end) begin
                    state_d = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = at_mid;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Index is only meaningful inside DATA; park it at 0.
                        bit_cnt_d = 4'd0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = at_mid;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = at_mid;
                if (bit_end) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Checker flags are registered, so they are stable here.
                edge_cnt_d   = 6'd0;
                bit_cnt_d    = 4'd0;
                state_d      = IDLE;
                data_valid_d = !stp_err && (!par_en_q || !par_err);
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= 4'd0;
            par_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign data_valid = data_valid_q;

`ifdef UART_RX_BREAK_DET_EN
    // Flag records whether any data bit was 1; a break is an all-zero
    // frame whose stop bit is also low.
    logic brk_flag_q, brk_flag_d;
    logic brk_det_q, brk_det_d;

    always_comb begin
        brk_flag_d = brk_flag_q;
        brk_det_d  = 1'b0;
        if (start_det) begin
            brk_flag_d = 1'b0;
        end else if (state_q == DATA && at_mid) begin
            brk_flag_d = brk_flag_q | sampled_bit;
        end
        if (state_q == CHECK) begin
            brk_det_d = !brk_flag_q && stp_err;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            brk_flag_q <= 1'b0;
            brk_det_q  <= 1'b0;
        end else begin
            brk_flag_q <= brk_flag_d;
            brk_det_q  <= brk_det_d;
        end
    end

    assign brk_det = brk_det_q;
`else
    // The sampler bit only feeds break detection.
    logic unused_sampled_bit;
    logic unused_start_det;
    assign unused_sampled_bit = sampled_bit;
    assign unused_start_det   = start_det;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have CLK  input  1  oversampling clock, all logic on rising edge.
REQ-003 SHALL have RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have RX_IN  input  1  serial line, idle high.
REQ-005 SHALL have PAR_EN  input  1  parity bit present in frame.
REQ-006 SHALL have PRESCALE  input  6  oversampling ratio; legal 8, 16, 32; other values undefined.
REQ-007 SHALL have sampled_bit  input  1  majority-voted bit from data sampler.
REQ-008 SHALL have strt_glitch, par_err, stp_err  input  1 each  registered checker results.
REQ-009 SHALL have dat_samp_en  output  1  data sampler enable.
REQ-010 SHALL have strt_chk_en, par_chk_en, stp_chk_en, deser_en  output  1 each  single-cycle strobes.
REQ-011 SHALL have edge_cnt  output  6  oversample tick within current bit.
REQ-012 SHALL have bit_cnt  output  4  data-bit index within DATA state.
REQ-013 SHALL have data_valid  output  1  one-cycle pulse, frame received error-free.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, CHECK.
REQ-015 IDLE: RX_IN==0 sampled -> START next cycle, edge_cnt=0, bit_cnt=0; PAR_EN latched into par_en_q on this transition.
REQ-016 edge_cnt SHALL increment every cycle outside IDLE/CHECK and wrap PRESCALE-1 -> 0; a wrap marks bit end.
REQ-017 mid-point tick M SHALL equal (PRESCALE>>1)+2; checker/deser strobes SHALL pulse exactly one cycle when edge_cnt==M.
REQ-018 START: strt_chk_en at M; at bit end strt_glitch==1 -> IDLE, else -> DATA.
REQ-019 DATA: deser_en at M; bit_cnt increments at each bit end; at bit end with bit_cnt==DATA_WIDTH-1 -> PARITY if par_en_q else STOP.
REQ-020 PARITY: par_chk_en at M; bit end -> STOP.
REQ-021 STOP: stp_chk_en at M; bit end -> CHECK.
REQ-022 CHECK: lasts exactly one cycle, then -> IDLE unconditionally.
REQ-023 data_valid SHALL be registered, high exactly the cycle after CHECK, iff stp_err==0 and (par_en_q==0 or par_err==0) as seen in CHECK.
REQ-024 dat_samp_en SHALL be high in START, DATA, PARITY, STOP; low in IDLE, CHECK.
REQ-025 PAR_EN changes mid-frame SHALL be ignored until next IDLE->START.
REQ-026 RX_IN low during CHECK SHALL be ignored; start detected from IDLE next cycle.
REQ-027 edge_cnt and bit_cnt SHALL hold 0 in IDLE and CHECK.

Reset
REQ-028 RST low SHALL asynchronously force state IDLE, all counters 0, all outputs 0, par_en_q 0.
REQ-029 RST assertion mid-frame SHALL abort frame with no data_valid; after release, next RX_IN low starts a new frame.

Configuration
REQ-030 macro UART_RX_BREAK_DET_EN SHALL, when defined, add output brk_det (1 bit, reset 0).
REQ-031 with macro: controller SHALL OR sampled_bit into a flag at each DATA deser_en strobe (cleared on IDLE->START); brk_det SHALL pulse one cycle with data_valid timing iff flag==0 and stp_err==1.
REQ-032 without macro: brk_det port and flag logic SHALL not exist; all other behaviour identical.

Verification
REQ-033 PRESCALE=8, PAR_EN=0, frame 0xA5 stop=1 -> deser_en 8 pulses at edge_cnt==6, data_valid one pulse, state IDLE after.
REQ-034 PRESCALE=16, PAR_EN=1, frame 0x3C even parity, par_err forced 1 -> par_chk_en one pulse, data_valid stays 0.
REQ-035 PRESCALE=8, RX_IN low 2 cycles, strt_glitch=1 -> return to IDLE at START bit end, no deser_en, no data_valid.
REQ-036 PRESCALE=32, stp_err=1 at CHECK -> data_valid 0; with UART_RX_BREAK_DET_EN and data 0x00 -> brk_det one pulse.
REQ-037 RST low during DATA bit 4 -> all outputs 0 immediately; clean frame 0x81 after release -> data_valid one pulse.
REQ-038 PAR_EN toggled 0->1 in DATA -> frame completes without PARITY state, data_valid pulses.
